// File: rtl/bp_be_lce_req_responder.sv
// Single-outstanding stand-in LCE: accepts D$ miss/uncached requests and answers with tag and data fills
// out of a small backing memory. Define BP_LCE_RESP_RANDOM_LATENCY_EN to add LFSR jitter to the wait time.
module bp_be_lce_req_responder #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int fill_width_p  = 128,
  parameter int mem_els_p     = 256,
  parameter int latency_p     = 4,
  localparam int IDX_W  = $clog2(sets_p),
  localparam int WAY_W  = $clog2(assoc_p),
  localparam int OFF_W  = $clog2(block_width_p / 8),
  localparam int BEATS  = block_width_p / fill_width_p,
  localparam int BEAT_W = $clog2(BEATS),
  localparam int TAG_W  = paddr_width_p - IDX_W - OFF_W,
  localparam int REQ_W  = 3 + 2 + paddr_width_p + 64,
  localparam int TPKT_W = WAY_W + IDX_W + TAG_W + 2,
  localparam int DPKT_W = 1 + WAY_W + IDX_W + BEAT_W + fill_width_p
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [REQ_W-1:0]  cache_req_i,
  input  logic              cache_req_v_i,
  output logic              cache_req_yumi_o,
  output logic              cache_req_busy_o,
  input  logic [WAY_W-1:0]  cache_req_metadata_i,
  input  logic              cache_req_metadata_v_i,
  output logic [TPKT_W-1:0] tag_mem_pkt_o,
  output logic              tag_mem_pkt_v_o,
  input  logic              tag_mem_pkt_yumi_i,
  output logic [DPKT_W-1:0] data_mem_pkt_o,
  output logic              data_mem_pkt_v_o,
  input  logic              data_mem_pkt_yumi_i,
  output logic              cache_req_critical_tag_o,
  output logic              cache_req_critical_data_o,
  output logic              cache_req_complete_o,
  output logic              cache_req_credits_full_o,
  output logic              cache_req_credits_empty_o
);

  localparam int MEM_W       = $clog2(mem_els_p);
  localparam int DW_PER_BLK  = block_width_p / 64;
  localparam int DW_PER_BEAT = fill_width_p / 64;
  localparam int MDW_W       = MEM_W + $clog2(DW_PER_BLK);
  localparam int MEM_DW      = mem_els_p * DW_PER_BLK;
  localparam int CNT_W       = $clog2(latency_p + 8) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_TAG  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [2:0]               r_type;
  logic [1:0]               r_size;
  logic [paddr_width_p-1:0] r_addr;
  logic [63:0]              r_data;
  logic [WAY_W-1:0]         r_way;
  logic [CNT_W-1:0]         r_cnt;
  logic [BEAT_W-1:0]        r_beat;
  logic                     r_first;
  logic                     r_crit_tag;
  logic                     r_crit_data;
  logic [63:0]              r_mem [MEM_DW];
  logic [MEM_DW-1:0]        r_mem_vld;

  logic                     w_accept;
  logic                     w_mem_we;
  logic                     w_tag_fire;
  logic                     w_data_fire;
  logic                     w_is_ucd;
  logic                     w_last_beat;
  logic [CNT_W-1:0]         w_cnt_dec;
  logic [CNT_W-1:0]         w_cnt_load;
  logic [MEM_W-1:0]         w_blk;
  logic [MDW_W-1:0]         w_ucd_idx;
  logic [63:0]              w_ucd_data;
  logic [fill_width_p-1:0]  w_fill_data;
  logic [IDX_W-1:0]         w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic [TPKT_W-1:0]        w_tag_pkt;
  logic [DPKT_W-1:0]        w_data_pkt;
  logic                     w_unused;

  // Unwritten dwords read back their own byte address within the backing store.
  function automatic logic [63:0] f_dw_read(input logic vld, input logic [63:0] stored,
                                            input logic [MDW_W-1:0] idx);
    if (vld) begin
      f_dw_read = stored;
    end else begin
      f_dw_read = 64'({idx, 3'b000});
    end
  endfunction

  function automatic logic [MDW_W-1:0] f_fill_idx(input logic [MEM_W-1:0] blk,
                                                 input logic [BEAT_W-1:0] beat, input int k);
    f_fill_idx = MDW_W'(int'(blk) * DW_PER_BLK + int'(beat) * DW_PER_BEAT + k);
  endfunction

  assign w_cnt_dec   = r_cnt - CNT_W'(1);
  assign w_tag_fire  = (r_state == S_TAG) & tag_mem_pkt_yumi_i;
  assign w_data_fire = (r_state == S_DATA) & data_mem_pkt_yumi_i;
  assign w_is_ucd    = (r_type == 3'd2);
  assign w_last_beat = w_is_ucd | (r_beat == BEAT_W'(BEATS - 1));
  assign w_blk       = r_addr[OFF_W+MEM_W-1:OFF_W];
  assign w_ucd_idx   = r_addr[OFF_W+MEM_W-1:3];
  assign w_idx       = r_addr[IDX_W+OFF_W-1:OFF_W];
  assign w_tag       = r_addr[paddr_width_p-1:IDX_W+OFF_W];
  assign w_ucd_data  = f_dw_read(r_mem_vld[w_ucd_idx], r_mem[w_ucd_idx], w_ucd_idx);
  assign w_unused    = ^{r_size, r_addr[2:0]};

`ifdef BP_LCE_RESP_RANDOM_LATENCY_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cnt_load = CNT_W'(latency_p) + CNT_W'(r_lfsr[2:0]);

  // Latency jitter source, stepped once per accepted request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  assign w_cnt_load = CNT_W'(latency_p);
`endif

  // Gather the dwords of the current fill beat.
  always_comb begin
    w_fill_data = {fill_width_p{1'b0}};
    for (int k = 0; k < DW_PER_BEAT; k++) begin
      w_fill_data[k*64 +: 64] = f_dw_read(r_mem_vld[f_fill_idx(w_blk, r_beat, k)],
                                          r_mem[f_fill_idx(w_blk, r_beat, k)],
                                          f_fill_idx(w_blk, r_beat, k));
    end
  end

  // Next-state decode; the uncached store commits as the wait expires.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cache_req_v_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_cnt_dec == {CNT_W{1'b0}}) begin
          case (r_type)
            3'd0, 3'd1: w_state_nxt = S_TAG;
            3'd2:       w_state_nxt = S_DATA;
            3'd3: begin
              w_mem_we    = 1'b1;
              w_state_nxt = S_DONE;
            end
            default:    w_state_nxt = S_DONE;
          endcase
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_TAG: begin
        if (tag_mem_pkt_yumi_i) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_TAG;
        end
      end
      S_DATA: begin
        if (w_data_fire && w_last_beat) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request context, wait counter, beat counter and status pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_type      <= 3'd0;
      r_size      <= 2'd0;
      r_addr      <= {paddr_width_p{1'b0}};
      r_data      <= 64'd0;
      r_way       <= {WAY_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_beat      <= {BEAT_W{1'b0}};
      r_first     <= 1'b0;
      r_crit_tag  <= 1'b0;
      r_crit_data <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_first     <= w_accept;
      r_crit_tag  <= w_tag_fire;
      r_crit_data <= w_data_fire & (r_beat == {BEAT_W{1'b0}});
      if (w_accept) begin
        {r_type, r_size, r_addr, r_data} <= cache_req_i;
        r_way  <= {WAY_W{1'b0}};
        r_cnt  <= w_cnt_load;
        r_beat <= {BEAT_W{1'b0}};
      end else begin
        if (r_first && cache_req_metadata_v_i) begin
          r_way <= cache_req_metadata_i;
        end
        if (r_state == S_WAIT) begin
          r_cnt <= w_cnt_dec;
        end
        if (w_data_fire && !w_is_ucd) begin
          r_beat <= r_beat + BEAT_W'(1);
        end
      end
    end
  end

  // Backing store payload; only written dwords are tracked, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_ucd_idx] <= r_data;
    end
  end

  // Written-dword flags; clearing them restores the initial memory image.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem_vld <= {MEM_DW{1'b0}};
    end else if (w_mem_we) begin
      r_mem_vld[w_ucd_idx] <= 1'b1;
    end else begin
      r_mem_vld <= r_mem_vld;
    end
  end

  assign w_tag_pkt  = {r_way, w_idx, w_tag, (r_type[0] ? 2'b11 : 2'b01)};
  assign w_data_pkt = {w_is_ucd, r_way, w_idx,
                       (w_is_ucd ? {BEAT_W{1'b0}} : r_beat),
                       (w_is_ucd ? fill_width_p'(w_ucd_data) : w_fill_data)};

  assign cache_req_busy_o          = (r_state != S_IDLE);
  assign cache_req_yumi_o          = cache_req_v_i & (r_state == S_IDLE);
  assign cache_req_credits_full_o  = cache_req_busy_o;
  assign cache_req_credits_empty_o = ~cache_req_busy_o;
  assign tag_mem_pkt_v_o           = (r_state == S_TAG);
  assign data_mem_pkt_v_o          = (r_state == S_DATA);
  assign tag_mem_pkt_o             = tag_mem_pkt_v_o ? w_tag_pkt : {TPKT_W{1'b0}};
  assign data_mem_pkt_o            = data_mem_pkt_v_o ? w_data_pkt : {DPKT_W{1'b0}};
  assign cache_req_critical_tag_o  = r_crit_tag;
  assign cache_req_critical_data_o = r_crit_data;
  assign cache_req_complete_o      = (r_state == S_DONE);

endmodule

// File: doc/bp_be_lce_req_responder.md
Name: bp_be_lce_req_responder

Overview:
- Consumes back-end D$ miss and uncached requests (`cache_req`, valid/yumi) and returns tag and data fills over the `tag_mem` / `data_mem` packet interfaces.
- Drives critical/complete/credit status back to the cache.
- Serves as a single-outstanding stand-in LCE with a small backing memory, for BE-level integration and unit benches.

Parameters:
- paddr_width_p, 40, physical address width
- sets_p, 64, D$ sets (idx_w = log2(sets_p))
- assoc_p, 8, D$ ways (way_w = log2(assoc_p))
- block_width_p, 512, cache block bits (offset_w = log2(block_width_p/8))
- fill_width_p, 128, bits per fill beat (beats = block_width_p/fill_width_p)
- mem_els_p, 256, backing blocks (mem_w = log2(mem_els_p))
- latency_p, 4, cycles from accept to first response, minimum 1

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- cache_req_i  in  3+2+paddr_width_p+64  request, MSB first: {type[2:0], size[1:0], addr, data[63:0]}
- cache_req_v_i  in  1  request valid
- cache_req_yumi_o  out  1  request accepted
- cache_req_busy_o  out  1  responder cannot accept
- cache_req_metadata_i  in  way_w  fill way
- cache_req_metadata_v_i  in  1  metadata valid
- tag_mem_pkt_o  out  way_w+idx_w+tag_w+2  {way, index, tag, state}; tag_w = paddr_width_p-idx_w-offset_w
- tag_mem_pkt_v_o  out  1  tag packet valid
- tag_mem_pkt_yumi_i  in  1  tag packet consumed
- data_mem_pkt_o  out  1+way_w+idx_w+log2(beats)+fill_width_p  {uncached, way, index, beat, data}
- data_mem_pkt_v_o  out  1  data packet valid
- data_mem_pkt_yumi_i  in  1  data packet consumed
- cache_req_critical_tag_o  out  1  pulse: tag written
- cache_req_critical_data_o  out  1  pulse: first data beat written
- cache_req_complete_o  out  1  pulse: request finished
- cache_req_credits_full_o  out  1  one request outstanding
- cache_req_credits_empty_o  out  1  none outstanding

Behaviour:
- Request types:
  - 0: load miss
  - 1: store miss
  - 2: uncached load
  - 3: uncached store
  - 4–7: unsupported
- Memory:
  - Backing block select = addr[offset_w+mem_w-1:offset_w]; higher address bits alias.
  - At reset, the dword at byte offset o of block b holds 64'(b*block_width_p/8+o).
- Outputs at reset:
  - All outputs 0, except cache_req_credits_empty_o = 1.
  - State = IDLE.
  - Reset asserted mid-request aborts it immediately; no complete pulse. Memory reinitialises.
- busy_o = (state != IDLE). credits_full_o = busy_o. credits_empty_o = !busy_o.
- IDLE:
  - yumi_o = v_i & !busy_o, combinational.
  - On accept, latch type, size, addr and data. Clear the latched way to 0. Load the latency counter with latency_p. Go to WAIT.
- WAIT:
  - If metadata_v_i is high in the cycle after accept, latch the way.
  - Decrement the counter each cycle. At 0:
    - miss types go to TAG;
    - type 2 goes to DATA with 1 beat;
    - type 3 writes data to the addressed 8-byte-aligned dword (size ignored), then goes to DONE;
    - types 4–7 go to DONE.
- TAG:
  - Hold tag_mem_pkt_v_o = 1 with {way, index, tag, state}. state = 2'b01 for load miss, 2'b11 for store miss.
  - On tag_mem_pkt_yumi_i: pulse critical_tag_o for 1 cycle, go to DATA.
- DATA:
  - Hold data_mem_pkt_v_o = 1.
  - For a fill: beat = beat counter, data = block bits [beat*fill_width_p +: fill_width_p], uncached = 0.
  - For uncached: beat = 0, data = addressed dword zero-extended, uncached = 1.
  - Each yumi advances the beat counter. Yumi on beat 0 pulses critical_data_o.
  - After yumi on the last beat, go to DONE.
  - Valid and packet fields must stay stable until yumi.
- DONE: assert complete_o for exactly 1 cycle, then go to IDLE. A new accept is possible the following cycle.
- Minimum total latency for a load miss = 1 + latency_p + 1 + beats + 1 cycles with yumi tied high.
- Store miss returns memory data unmerged; the cache merges the store data after the fill.

Optional Feature:
- Macro: BP_LCE_RESP_RANDOM_LATENCY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances on every accept.
  - WAIT count = latency_p + lfsr[2:0].
- Undefined: count is exactly latency_p, and no LFSR logic is present.

Test Plan:
- Load miss at addr 0x0000_0040, metadata way 3, yumis tied high:
  - tag pkt {3, 1, 0, 01};
  - 4 beats carrying dwords 0x40..0x78 in order;
  - critical_tag, then critical_data, then complete 1 cycle each;
  - first tag valid at cycle latency_p+1 after accept.
- Uncached store of data 0xDEAD_BEEF to 0x108, then uncached load of 0x108:
  - store: complete with no tag/data packets;
  - load: single data pkt with uncached=1, data 0xDEAD_BEEF.
- Back-to-back requests with v_i held high: second yumi_o held 0 until the cycle after complete; credits_full_o = 1 throughout.
- data_mem_pkt_yumi_i stalled 5 cycles on beat 2: packet fields stable; beat 3 follows only after yumi.
- reset_i asserted during DATA beat 1:
  - all valids drop asynchronously, credits_empty_o = 1;
  - a post-reset load of 0x108 returns 0x108 (memory reinitialised).
- Type 5 request: no packets; complete after latency_p+1 cycles.
